// File: rtl/sw_led_ctrl.sv
// Switch-to-LED controller: per-channel 2-flop sync, counter debounce, edge pulses,
// and an LED output register with direct / inverted / toggle-latch / blink modes.
module sw_led_ctrl #(
  parameter int unsigned N               = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLINK_HALF      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic [1:0]   mode,
  input  logic         clr,
  output logic [N-1:0] ld,
  output logic [N-1:0] chg
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned BW = $clog2(BLINK_HALF) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_INVERT = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  logic [N-1:0]  s1, s2, db, db_d, tog;
  logic [CW-1:0] cnt [N];
  logic [BW-1:0] bcnt;
  logic          phase;

  logic [N-1:0]  rise_c, fall_c, tog_next_c, ld_next_c;

  // Synchroniser and per-channel debounce: a new level must persist DEBOUNCE_CYCLES samples
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < int'(N); i++) cnt[i] <= '0;
    end else begin
      s1   <= sw;
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < int'(N); i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Free-running blink timebase, independent of mode and clr
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BCNT_LAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

  // Edge detect, toggle-latch next value and output mode mux
  always_comb begin
    rise_c     = db & ~db_d;
    fall_c     = ~db & db_d;
    tog_next_c = clr ? '0 : (tog ^ rise_c);
    ld_next_c  = db;
    case (mode_e'(mode))
      MODE_DIRECT: ld_next_c = db;
      MODE_INVERT: ld_next_c = ~db;
      MODE_TOGGLE: ld_next_c = tog_next_c;
      MODE_BLINK:  ld_next_c = db & {N{phase}};
      default:     ld_next_c = db;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tog <= '0;
      ld  <= '0;
      chg <= '0;
    end else begin
      tog <= tog_next_c;
      ld  <= ld_next_c;
      chg <= rise_c | fall_c;
    end
  end

endmodule
